// File: rtl/pc_fetch_unit_if.sv
// +----------------------------------------------------------------------+
// | pc_fetch_unit_if                                                     |
// | Decoder/program-memory bus for the PIC16F fetch unit.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_unit_if;
  logic        pc_incr_en;
  logic        pc_j_en;
  logic        pc_j_and_push_en;
  logic        pc_j_by_pop_en;
  logic        instr_rd_en;
  logic        instr_flush;
  logic [10:0] j_addr;
  logic [4:0]  pclath;
  logic        pcl_wr_en;
  logic [7:0]  pcl_wr_data;
  logic [12:0] prog_addr;
  logic [13:0] prog_data;
  logic [13:0] instr_current;
  logic [7:0]  pcl;
  logic        stack_ovf;
  logic        stack_unf;

  // Master is the decoder plus program memory (memory returns prog_data).
  modport master (
    output pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
    output instr_rd_en, instr_flush, j_addr, pclath, pcl_wr_en, pcl_wr_data,
    output prog_data,
    input  prog_addr, instr_current, pcl, stack_ovf, stack_unf
  );

  modport slave (
    input  pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
    input  instr_rd_en, instr_flush, j_addr, pclath, pcl_wr_en, pcl_wr_data,
    input  prog_data,
    output prog_addr, instr_current, pcl, stack_ovf, stack_unf
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// +----------------------------------------------------------------------+
// | pc_fetch_unit                                                        |
// | PC, circular return stack and instruction register for the PIC16F.   |
// | Optional sticky stack flags: define PC_STACK_FLAGS_EN.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_fetch_unit #(
  parameter int          STACK_DEPTH = 8,
  parameter logic [13:0] NOP_WORD    = 14'h0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pc_fetch_unit_if.slave   bus
);

  localparam int               c_SP_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [c_SP_W-1:0] c_SP_ONE = c_SP_W'(1);

  logic [12:0]       pc_q, pc_d;
  logic [13:0]       ir_q;
  logic [c_SP_W-1:0] sp_q, sp_d;
  logic [12:0]       stack_q [STACK_DEPTH];

  logic              w_push;
  logic              w_pop;
  logic [c_SP_W-1:0] w_sp_dec;

  assign w_sp_dec = sp_q - c_SP_ONE;

  // One PC action per cycle; the priority chain also guarantees push/pop exclusivity.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (bus.pcl_wr_en) begin
      pc_d = {bus.pclath, bus.pcl_wr_data};
    end else if (bus.pc_j_by_pop_en) begin
      w_pop = 1'b1;
      sp_d  = w_sp_dec;
      pc_d  = stack_q[w_sp_dec];
    end else if (bus.pc_j_and_push_en) begin
      w_push = 1'b1;
      sp_d   = sp_q + c_SP_ONE;
      pc_d   = {bus.pclath[4:3], bus.j_addr};
    end else if (bus.pc_j_en) begin
      pc_d = {bus.pclath[4:3], bus.j_addr};
    end else if (bus.pc_incr_en) begin
      pc_d = pc_q + 13'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= 13'd0;
      sp_q <= '0;
    end else begin
      pc_q <= pc_d;
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= NOP_WORD;
    end else if (bus.instr_flush) begin
      ir_q <= NOP_WORD;
    end else if (bus.instr_rd_en) begin
      ir_q <= bus.prog_data;
    end
  end

  // Stack contents are deliberately not reset; the prefetch PC is already the return address.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      stack_q[sp_q] <= pc_q;
    end
  end

  assign bus.prog_addr     = pc_q;
  assign bus.pcl           = pc_q[7:0];
  assign bus.instr_current = ir_q;

`ifdef PC_STACK_FLAGS_EN
  localparam int                c_CNT_W   = $clog2(STACK_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(STACK_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [c_CNT_W-1:0] cnt_q;
  logic               ovf_q;
  logic               unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (w_push) begin
      if (cnt_q == c_FULL) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + c_CNT_ONE;
      end
    end else if (w_pop) begin
      if (cnt_q == '0) begin
        unf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - c_CNT_ONE;
      end
    end
  end

  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
`else
  assign bus.stack_ovf = 1'b0;
  assign bus.stack_unf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_pc_fetch_unit                                                     |
// | Scoreboard bench for pc_fetch_unit with a behavioural fetch model.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch_unit;

  localparam int          DEPTH = 8;
  localparam int          NOP   = 14'h0000;
`ifdef PC_STACK_FLAGS_EN
  localparam bit          FLAGS_ON = 1'b1;
`else
  localparam bit          FLAGS_ON = 1'b0;
`endif

  typedef struct {
    string nm;
    int    pc;
    int    ir;
    bit    ovf;
    bit    unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pc_fetch_unit_if bus();

  logic [13:0] mem [8192];
  exp_t        sbq [$];
  int          n_pass  = 0;
  int          n_total = 0;

  // Reference model state: plain integers, stack as an indexed ring.
  int m_pc, m_ir, m_sp, m_cnt;
  bit m_ovf, m_unf;
  int m_stk [DEPTH];
  bit m_wr  [DEPTH];

  pc_fetch_unit #(.STACK_DEPTH(DEPTH), .NOP_WORD(14'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.prog_data = mem[bus.prog_addr];

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.nm, "prog_addr",     int'(bus.prog_addr),     e.pc);
      chk(e.nm, "pcl",           int'(bus.pcl),           e.pc % 256);
      chk(e.nm, "instr_current", int'(bus.instr_current), e.ir);
      chk(e.nm, "stack_ovf",     int'(bus.stack_ovf),     int'(e.ovf));
      chk(e.nm, "stack_unf",     int'(bus.stack_unf),     int'(e.unf));
    end
  end

  task automatic cyc(input string nm, input bit r, input bit incr, input bit j, input bit call,
                     input bit ret, input bit rd, input bit fl, input bit pw,
                     input int ja, input int pl, input int wd);
    exp_t e;
    @(negedge clk);
    rst                  = r;
    bus.pc_incr_en       = incr;
    bus.pc_j_en          = j;
    bus.pc_j_and_push_en = call;
    bus.pc_j_by_pop_en   = ret;
    bus.instr_rd_en      = rd;
    bus.instr_flush      = fl;
    bus.pcl_wr_en        = pw;
    bus.j_addr           = 11'(ja);
    bus.pclath           = 5'(pl);
    bus.pcl_wr_data      = 8'(wd);
    if (r) begin
      m_pc = 0; m_ir = NOP; m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (fl)      m_ir = NOP;
      else if (rd) m_ir = int'(mem[m_pc]);
      if (pw) begin
        m_pc = (pl % 32) * 256 + (wd % 256);
      end else if (ret) begin
        if (m_cnt == 0) m_unf = 1; else m_cnt--;
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        m_pc = m_stk[m_sp];
      end else if (call) begin
        if (m_cnt == DEPTH) m_ovf = 1; else m_cnt++;
        m_stk[m_sp] = m_pc;
        m_wr[m_sp]  = 1;
        m_sp = (m_sp + 1) % DEPTH;
        m_pc = ((pl / 8) % 4) * 2048 + (ja % 2048);
      end else if (j) begin
        m_pc = ((pl / 8) % 4) * 2048 + (ja % 2048);
      end else if (incr) begin
        m_pc = (m_pc + 1) % 8192;
      end
    end
    e.nm  = nm;
    e.pc  = m_pc;
    e.ir  = m_ir;
    e.ovf = FLAGS_ON & m_ovf;
    e.unf = FLAGS_ON & m_unf;
    sbq.push_back(e);
  endtask

  task automatic idle(input string nm);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic setpc(input string nm, input int pc);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 1, 0, pc / 256, pc % 256);
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 14'($urandom);
    mem[1] = 14'h3005;
    for (int k = 0; k < DEPTH; k++) begin m_stk[k] = 0; m_wr[k] = 0; end
    bus.pc_incr_en = 0; bus.pc_j_en = 0; bus.pc_j_and_push_en = 0; bus.pc_j_by_pop_en = 0;
    bus.instr_rd_en = 0; bus.instr_flush = 0; bus.pcl_wr_en = 0;
    bus.j_addr = 0; bus.pclath = 0; bus.pcl_wr_data = 0;

    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("idle");
    cyc("incr_to_1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("fetch", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("goto", 0, 0, 1, 0, 0, 0, 1, 0, 'h123, 5'b11000, 0);

    setpc("set_0010", 'h0010);
    cyc("call", 0, 0, 0, 1, 0, 0, 1, 0, 'h200, 0, 0);
    cyc("return", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

    cyc("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      setpc("ovf_set", i);
      cyc("ovf_call", 0, 0, 0, 1, 0, 0, 0, 0, 'h300 + i, 0, 0);
    end
    for (int i = 0; i < 8; i++) cyc("ovf_ret", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("unf_ret", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    cyc("prio_pclwr", 0, 1, 1, 1, 1, 0, 0, 1, 'h7FF, 5'h01, 'hAB);
    cyc("prio_pop", 0, 1, 1, 1, 1, 0, 0, 0, 'h155, 5'h1F, 0);
    cyc("prio_push", 0, 1, 1, 1, 0, 1, 0, 0, 'h2AA, 5'h08, 0);
    cyc("prio_flush", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc("prio_rd", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    setpc("set_1fff", 'h1FFF);
    cyc("wrap", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("reset_vs_j", 1, 0, 1, 0, 0, 1, 0, 0, 'h7FF, 5'h1F, 0);

    for (int n = 0; n < 1500; n++) begin
      bit r, incr, j, call, ret, rd, fl, pw;
      r    = ($urandom_range(0, 63) == 0);
      incr = ($urandom_range(0, 1) == 0);
      j    = ($urandom_range(0, 5) == 0);
      call = ($urandom_range(0, 5) == 0);
      ret  = ($urandom_range(0, 5) == 0);
      rd   = ($urandom_range(0, 1) == 0);
      fl   = ($urandom_range(0, 7) == 0);
      pw   = ($urandom_range(0, 9) == 0);
      if (ret && !m_wr[(m_sp + DEPTH - 1) % DEPTH]) ret = 0;
      cyc("random", r, incr, j, call, ret, rd, fl, pw,
          int'($urandom_range(0, 2047)), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    end
    idle("tail");

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program counter, 8-level hardware return stack and instruction register for the PIC16F core. Sits directly upstream of the instruction decoder: presents program-memory addresses, latches fetched words into `instr_current`, and executes the decoder's PC commands (increment, jump, call, return) and instruction flushes. The prefetch model gives 4-cycle straight-line instructions and 8-cycle branches.

## Interface
- `STACK_DEPTH`, default 8: return-stack entries; must be a power of two.
- `NOP_WORD`, default 14'h0000: word loaded into the instruction register on flush and reset.
---
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_incr_en`  in  1  PC <= PC+1.
- `pc_j_en`  in  1  goto: PC <= {pclath[4:3], j_addr}.
- `pc_j_and_push_en`  in  1  call: push PC, then jump as goto.
- `pc_j_by_pop_en`  in  1  return: PC <= popped entry.
- `instr_rd_en`  in  1  instruction register <= `prog_data`.
- `instr_flush`  in  1  instruction register <= `NOP_WORD`.
- `j_addr`  in  11  jump target, from `instr_current[10:0]`.
- `pclath`  in  5  PCLATH register contents.
- `pcl_wr_en`  in  1  computed goto: PC <= {pclath, pcl_wr_data}.
- `pcl_wr_data`  in  8  new PCL value.
- `prog_addr`  out  13  program-memory address; equals PC.
- `prog_data`  in  14  program-memory word, combinational from `prog_addr`.
- `instr_current`  out  14  instruction register, consumed by the decoder.
- `pcl`  out  8  PC[7:0], for reads of PCL.
- `stack_ovf`  out  1  sticky push-overflow flag. Requires `PC_STACK_FLAGS_EN`.
- `stack_unf`  out  1  sticky pop-underflow flag. Requires `PC_STACK_FLAGS_EN`.

## Operation
- **State:**
  - PC: 13 bits.
  - Instruction register (IR): 14 bits.
  - Stack: `STACK_DEPTH` × 13 bits.
  - Stack pointer `sp`: log2(`STACK_DEPTH`) bits. Points at the next free slot.
  - Occupancy count: 0..`STACK_DEPTH`, used for the flags.
- **Reset values:** PC=0, IR=`NOP_WORD`, sp=0, count=0, flags=0, so `prog_addr`=0 and `pcl`=0. Stack contents are not reset.
- **PC update priority**, one action per cycle, highest first:
  1. `pcl_wr_en`
  2. `pc_j_by_pop_en`
  3. `pc_j_and_push_en`
  4. `pc_j_en`
  5. `pc_incr_en`
  6. Otherwise PC holds.
- **Increment:** PC+1 modulo 2^13; 13'h1FFF wraps to 0.
- **Push (call):**
  - stack[sp] <= current PC. Under the prefetch model this is already the return address.
  - sp <= sp+1, wrapping circularly.
  - At full depth the oldest entry is overwritten and count stays at `STACK_DEPTH`.
- **Pop (return):**
  - PC <= stack[sp-1]; sp <= sp-1, wrapping.
  - At count 0 the wrapped entry is still used and count stays 0.
- **IR update:** `instr_flush` has priority over `instr_rd_en`. If neither is asserted, IR holds.
- IR updates and PC updates are independent. A single cycle may load IR from the old PC and change PC.
- `prog_addr` is the registered PC. No extra address register.

## Timing
- All state changes on the rising edge of `clk`.
- PC, `prog_addr` and `pcl` reflect an update one cycle after the enable.
- IR latches `prog_data` for the PC value present in the same cycle as `instr_rd_en`.
- Normal instruction at address A:
  - The decoder's q3 asserts `instr_rd_en` + `pc_incr_en` while PC=A+1.
  - IR <= word(A+1), PC <= A+2.
- Call or goto at q3: IR <= NOP, PC <= target. The flushed NOP runs one 4-cycle slot; its q3 fetches the target. Total 8 cycles.
- Return at q3: PC <= stack top, IR <= NOP. Same 8-cycle behaviour.
- Push and pop are never simultaneous, because priority selects one.
- `rst` asserted mid-operation overrides every enable in that cycle.

## Configuration
- **`PC_STACK_FLAGS_EN` defined:**
  - `stack_ovf` sets on a push when count==`STACK_DEPTH`.
  - `stack_unf` sets on a pop when count==0.
  - Both are sticky until `rst`.
- **Not defined:** both outputs are tied to 0, no occupancy counter is built, and wrap behaviour is unchanged.

## Test plan
- **Reset and straight-line fetch:** rst, then memory word(1)=14'h3005. Assert `instr_rd_en`+`pc_incr_en` at PC=1 → IR=14'h3005, PC=2, `pcl`=8'h02.
- **Goto:** pclath=5'b11000, j_addr=11'h123, `pc_j_en`+`instr_flush` → PC=13'h1923, IR=14'h0000.
- **Call/return:** call at PC=13'h0010 to 13'h0200, then `pc_j_by_pop_en` → PC=13'h0010, sp back to 0.
- **Overflow:** 9 calls from PCs 1..9, then 8 returns → returns yield 9,8,7,6,5,4,3,2, and `stack_ovf`=1 when the macro is defined.
- **Priority collisions:**
  - `pcl_wr_en` (data 8'hAB, pclath 5'h01) with `pc_incr_en` → PC=13'h01AB.
  - `instr_flush`+`instr_rd_en` → IR=NOP.
- **Wrap and reset:**
  - PC=13'h1FFF with `pc_incr_en` → PC=0.
  - `rst` asserted alongside `pc_j_en` → PC=0, IR=NOP, flags cleared.
